// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and default sizing for the IF->ID instruction fetch queue.
package inst_fetch_queue_pkg;

   typedef logic [31:0] virt_t;
   typedef logic [31:0] uint32_t;
   typedef logic [4:0]  exception_t;

   // One fetched instruction plus its prediction and exception tags.
   typedef struct packed {
      virt_t      pc;
      uint32_t    inst;
      logic       pred_taken;
      virt_t      pred_target;
      exception_t ex;
   } fq_entry_t;

   localparam int unsigned FQ_DEPTH     = 8;
   localparam int unsigned FQ_IN_WIDTH  = 2;
   localparam int unsigned FQ_OUT_WIDTH = 2;

endpackage

// File: rtl/inst_fetch_queue_compact.sv
// Packs the set slots of a fetch block towards slot 0 and counts them.
module inst_fetch_queue_compact
   import inst_fetch_queue_pkg::*;
#(
   parameter  int unsigned IN_WIDTH = FQ_IN_WIDTH,
   localparam int unsigned NUM_W    = $clog2(IN_WIDTH + 1)
) (
   input  logic                     [IN_WIDTH-1:0] mask,
   input  fq_entry_t [IN_WIDTH-1:0]                entries_in,
   output fq_entry_t [IN_WIDTH-1:0]                entries_out,
   output logic                     [NUM_W-1:0]    num
);

   logic [NUM_W-1:0] run;

   // Running prefix count picks the output position of each set slot.
   always_comb begin
      run         = '0;
      entries_out = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         for (int o = 0; o < IN_WIDTH; o++) begin
            if (mask[i] && (run == NUM_W'(o))) begin
               entries_out[o] = entries_in[i];
            end
         end
         run = run + NUM_W'(mask[i]);
      end
      num = run;
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// Multi-slot instruction buffer between fetch and decode, with flush and
// delay-slot-preserving branch correction.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter  int unsigned DEPTH     = FQ_DEPTH,
   parameter  int unsigned IN_WIDTH  = FQ_IN_WIDTH,
   parameter  int unsigned OUT_WIDTH = FQ_OUT_WIDTH,
   localparam int unsigned PTR_W     = $clog2(DEPTH),
   localparam int unsigned CNT_W     = $clog2(DEPTH + 1),
   localparam int unsigned DEQ_W     = $clog2(OUT_WIDTH + 1),
   localparam int unsigned ENQ_W     = $clog2(IN_WIDTH + 1)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 fs_valid,
   input  logic                  [IN_WIDTH-1:0] fs_slot_mask,
   input  fq_entry_t [IN_WIDTH-1:0]             fs_entries,
   output logic                                 fq_allowin,
   output logic                  [OUT_WIDTH-1:0] ds_valid,
   output fq_entry_t [OUT_WIDTH-1:0]            ds_entries,
   input  logic                  [DEQ_W-1:0]    ds_deq_cnt,
   input  logic                                 pipeline_flush,
   input  logic                                 bpu_flush,
   input  logic                                 keep_delay_slot,
   output logic                  [CNT_W-1:0]    fq_count
);

   logic [PTR_W-1:0]           head_q, tail_q, head_n, tail_n, head_deq;
   logic [CNT_W-1:0]           count_q, count_n, count_deq;
   logic                       pending_q, pending_n;
   logic                       flush_all, enq_fire, allowin_n;
   logic [OUT_WIDTH-1:0]       valid_n;
   logic [IN_WIDTH-1:0]        mask_sel;
   logic [ENQ_W-1:0]           enq_num;
   logic [DEQ_W-1:0]           avail;
   fq_entry_t [IN_WIDTH-1:0]   comp;
   fq_entry_t                  mem_q [DEPTH];

   // Slot mask actually offered for enqueue; a pending delay slot keeps only the lowest set slot.
   always_comb begin
      mask_sel = fs_valid ? fs_slot_mask : '0;
      if (pending_q) begin
         mask_sel = mask_sel & (~mask_sel + IN_WIDTH'(1));
      end
   end

   inst_fetch_queue_compact #(
      .IN_WIDTH    (IN_WIDTH)
   ) u_compact (
      .mask        (mask_sel),
      .entries_in  (fs_entries),
      .entries_out (comp),
      .num         (enq_num)
   );

   assign enq_fire  = fs_valid & fq_allowin & ~pipeline_flush & ~bpu_flush;
   assign flush_all = pipeline_flush | (bpu_flush & ~keep_delay_slot);
   assign head_deq  = head_q + PTR_W'(ds_deq_cnt);
   assign count_deq = count_q - CNT_W'(ds_deq_cnt);

   // Next pointer/occupancy state: full flush, delay-slot trim, or normal enq/deq.
   always_comb begin
      head_n    = head_q;
      tail_n    = tail_q;
      count_n   = count_q;
      pending_n = pending_q;
      if (flush_all) begin
         head_n    = '0;
         tail_n    = '0;
         count_n   = '0;
         pending_n = 1'b0;
      end else if (bpu_flush) begin
         head_n = head_deq;
         if (count_deq != '0) begin
            count_n = CNT_W'(1);
            tail_n  = head_deq + PTR_W'(1);
         end else begin
            count_n   = '0;
            tail_n    = head_deq;
            pending_n = 1'b1;
         end
      end else begin
         head_n  = head_deq;
         count_n = count_deq;
         if (enq_fire) begin
            tail_n  = tail_q + PTR_W'(enq_num);
            count_n = count_deq + CNT_W'(enq_num);
            if (mask_sel != '0) begin
               pending_n = 1'b0;
            end
         end
      end
   end

   // Status outputs precomputed from next occupancy so they leave flops.
   always_comb begin
      allowin_n = count_n <= CNT_W'(DEPTH - IN_WIDTH);
      valid_n   = '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         valid_n[i] = count_n > CNT_W'(i);
      end
   end

   // Pointer, occupancy and status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         pending_q  <= 1'b0;
         fq_allowin <= 1'b1;
         ds_valid   <= '0;
      end else begin
         head_q     <= head_n;
         tail_q     <= tail_n;
         count_q    <= count_n;
         pending_q  <= pending_n;
         fq_allowin <= allowin_n;
         ds_valid   <= valid_n;
      end
   end

   assign fq_count = count_q;

   // Storage write: compacted entries land at consecutive slots from tail.
   always_ff @(posedge clk) begin
      for (int j = 0; j < IN_WIDTH; j++) begin
         if (enq_fire && (ENQ_W'(j) < enq_num)) begin
            mem_q[tail_q + PTR_W'(j)] <= comp[j];
         end
      end
   end

   // Oldest entries presented in order from head.
   always_comb begin
      ds_entries = '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         ds_entries[i] = mem_q[head_q + PTR_W'(i)];
      end
   end

   // Entries visible to decode this cycle, used to police ds_deq_cnt.
   always_comb begin
      avail = (count_q >= CNT_W'(OUT_WIDTH)) ? DEQ_W'(OUT_WIDTH) : DEQ_W'(count_q);
   end

   deq_within_valid : assert property (@(posedge clk) disable iff (reset)
      flush_all || (ds_deq_cnt <= avail));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (DEPTH=8, IN=2, OUT=2).
module tb_inst_fetch_queue;
   import inst_fetch_queue_pkg::*;

   logic                clk = 1'b0;
   logic                reset;
   logic                fs_valid;
   logic [1:0]          fs_slot_mask;
   fq_entry_t [1:0]     fs_entries;
   logic                fq_allowin;
   logic [1:0]          ds_valid;
   fq_entry_t [1:0]     ds_entries;
   logic [1:0]          ds_deq_cnt;
   logic                pipeline_flush;
   logic                bpu_flush;
   logic                keep_delay_slot;
   logic [3:0]          fq_count;

   int total = 0;
   int bad   = 0;

   inst_fetch_queue dut (
      .clk             (clk),
      .reset           (reset),
      .fs_valid        (fs_valid),
      .fs_slot_mask    (fs_slot_mask),
      .fs_entries      (fs_entries),
      .fq_allowin      (fq_allowin),
      .ds_valid        (ds_valid),
      .ds_entries      (ds_entries),
      .ds_deq_cnt      (ds_deq_cnt),
      .pipeline_flush  (pipeline_flush),
      .bpu_flush       (bpu_flush),
      .keep_delay_slot (keep_delay_slot),
      .fq_count        (fq_count)
   );

   always #5 clk = ~clk;

   function automatic fq_entry_t mk(input logic [31:0] pc);
      fq_entry_t e;
      e.pc          = pc;
      e.inst        = ~pc;
      e.pred_taken  = 1'b0;
      e.pred_target = pc + 32'd8;
      e.ex          = 5'd0;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_q(input string tag, input int cnt, input logic [1:0] vld, input logic alw);
      chk({tag, "_count"}, 32'(fq_count), 32'(cnt));
      chk({tag, "_valid"}, 32'(ds_valid), 32'(vld));
      chk({tag, "_allowin"}, 32'(fq_allowin), 32'(alw));
   endtask

   task automatic drv(input logic v, input logic [1:0] m, input logic [31:0] pc,
                      input logic [1:0] deq, input logic pf, input logic bf, input logic kp);
      fs_valid        = v;
      fs_slot_mask    = m;
      fs_entries[0]   = mk(pc);
      fs_entries[1]   = mk(pc + 32'd4);
      ds_deq_cnt      = deq;
      pipeline_flush  = pf;
      bpu_flush       = bf;
      keep_delay_slot = kp;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      drv(1'b0, 2'b00, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
      #3;
      chk_q("reset", 0, 2'b00, 1'b1);
      tick();
      reset = 1'b0;

      // Fill to full with four two-slot blocks.
      for (int k = 0; k < 4; k++) begin
         drv(1'b1, 2'b11, 32'(8 * k), 2'd0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      chk_q("full", 8, 2'b11, 1'b0);
      chk("full_pc0", ds_entries[0].pc, 32'h00);
      chk("full_pc1", ds_entries[1].pc, 32'h04);
      chk("full_inst0", ds_entries[0].inst, 32'hffff_ffff);

      // Head freed while full: enqueue still refused.
      drv(1'b1, 2'b11, 32'h80, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      chk_q("bp_deq", 6, 2'b11, 1'b1);
      chk("bp_pc0", ds_entries[0].pc, 32'h08);
      chk("bp_pc1", ds_entries[1].pc, 32'h0c);

      // Reach count=5, tail=3, then reset asynchronously mid-cycle.
      drv(1'b1, 2'b11, 32'h20, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      chk("mid_count6", 32'(fq_count), 32'd6);
      chk("mid_pc0", ds_entries[0].pc, 32'h10);
      drv(1'b1, 2'b01, 32'h28, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      chk("mid_count5", 32'(fq_count), 32'd5);
      reset = 1'b1;
      drv(1'b0, 2'b00, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk_q("async_rst", 0, 2'b00, 1'b1);
      #2;
      reset = 1'b0;
      drv(1'b1, 2'b11, 32'h200, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk_q("no_bypass", 0, 2'b00, 1'b1);
      tick();
      chk_q("restart", 2, 2'b11, 1'b1);
      chk("restart_pc0", ds_entries[0].pc, 32'h200);
      chk("restart_pc1", ds_entries[1].pc, 32'h204);
      drv(1'b0, 2'b00, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();

      // Move tail to 7 with an empty queue.
      drv(1'b1, 2'b11, 32'h300, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      drv(1'b1, 2'b11, 32'h308, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      drv(1'b1, 2'b01, 32'h310, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      drv(1'b0, 2'b00, 32'h0, 2'd1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_q("pre_wrap", 0, 2'b00, 1'b1);

      // Partial mask at tail=7, then wrap into slots 0,1.
      drv(1'b1, 2'b10, 32'h18, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_q("wrap_one", 1, 2'b01, 1'b1);
      chk("wrap_pc0", ds_entries[0].pc, 32'h1c);
      drv(1'b1, 2'b11, 32'h20, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_q("wrap_three", 3, 2'b11, 1'b1);
      chk("wrap3_pc0", ds_entries[0].pc, 32'h1c);
      chk("wrap3_pc1", ds_entries[1].pc, 32'h20);

      // Simultaneous enqueue of 2 and dequeue of 2 at count=3.
      drv(1'b1, 2'b11, 32'h28, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      chk_q("simul", 3, 2'b11, 1'b1);
      chk("simul_pc0", ds_entries[0].pc, 32'h24);
      chk("simul_pc1", ds_entries[1].pc, 32'h28);
      drv(1'b0, 2'b00, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      chk_q("simul_tail", 1, 2'b01, 1'b1);
      chk("simul_tail_pc0", ds_entries[0].pc, 32'h2c);
      drv(1'b0, 2'b00, 32'h0, 2'd1, 1'b0, 1'b0, 1'b0);
      tick();

      // Delay slot kept: A, A+4, A+8; consume A with bpu_flush+keep.
      drv(1'b1, 2'b11, 32'h400, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      drv(1'b1, 2'b01, 32'h408, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("ds_fill", 32'(fq_count), 32'd3);
      drv(1'b1, 2'b11, 32'h900, 2'd1, 1'b0, 1'b1, 1'b1);
      tick();
      chk_q("ds_keep", 1, 2'b01, 1'b1);
      chk("ds_keep_pc0", ds_entries[0].pc, 32'h404);
      drv(1'b0, 2'b00, 32'h0, 2'd1, 1'b0, 1'b0, 1'b0);
      tick();

      // Delay slot pending: only the branch queued.
      drv(1'b1, 2'b01, 32'h500, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("pend_br_pc", ds_entries[0].pc, 32'h500);
      drv(1'b0, 2'b00, 32'h0, 2'd1, 1'b0, 1'b1, 1'b1);
      tick();
      chk_q("pend_empty", 0, 2'b00, 1'b1);
      drv(1'b1, 2'b00, 32'h580, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("pend_mask0", 32'(fq_count), 32'd0);
      drv(1'b1, 2'b11, 32'h600, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_q("pend_slot", 1, 2'b01, 1'b1);
      chk("pend_slot_pc", ds_entries[0].pc, 32'h600);
      drv(1'b1, 2'b11, 32'h700, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("pend_clr_cnt", 32'(fq_count), 32'd3);
      chk("pend_clr_pc1", ds_entries[1].pc, 32'h700);
      drv(1'b0, 2'b00, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      chk("pend_last_pc", ds_entries[0].pc, 32'h704);

      // Same flush with pipeline_flush: pending cleared, queue empty.
      drv(1'b0, 2'b00, 32'h0, 2'd1, 1'b1, 1'b1, 1'b1);
      tick();
      chk_q("pf_empty", 0, 2'b00, 1'b1);
      drv(1'b1, 2'b11, 32'h800, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_q("pf_after", 2, 2'b11, 1'b1);
      chk("pf_after_pc0", ds_entries[0].pc, 32'h800);
      chk("pf_after_pc1", ds_entries[1].pc, 32'h804);

      // Unknown fetch payload with fs_valid low changes nothing.
      drv(1'b0, 2'b00, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
      fs_slot_mask = 2'bxx;
      fs_entries   = 'x;
      tick();
      chk("x_idle_cnt", 32'(fq_count), 32'd2);
      chk("x_idle_pc0", ds_entries[0].pc, 32'h800);

      // bpu_flush without keep empties the queue.
      drv(1'b0, 2'b00, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_q("bf_nokeep", 0, 2'b00, 1'b1);

      drv(1'b0, 2'b00, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
